// File: rtl/int_divider_pkg.sv
// Shared execute-stage constants for the sequential divider: step count, state encoding
// and a decoder that names the current phase of the step counter.
package int_divider_pkg;

  localparam int DIV_STATE_W = 6;
  localparam logic [DIV_STATE_W-1:0] DIV_STEPS = 6'd32;
  localparam logic [DIV_STATE_W-1:0] DIV_DONE  = 6'd33;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_STEP,
    PH_DONE,
    PH_OVER
  } div_phase_e;

  function automatic div_phase_e divPhase(input logic [DIV_STATE_W-1:0] s);
    if (s == '0)
      return PH_LOAD;
    else if (s <= DIV_STEPS)
      return PH_STEP;
    else if (s == DIV_DONE)
      return PH_DONE;
    else
      return PH_OVER;
  endfunction

endpackage

// File: rtl/int_divider.sv
// Restoring 32-bit divider for the DIV instruction: unsigned, or floored signed with a
// positive divisor. One quotient bit per clock while the CPU is held in stall.
module int_divider
  import int_divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        u,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [DIV_STATE_W-1:0] sQ, sD;
  logic [31:0]            qQ, qD;
  logic [31:0]            rQ, rD;
  logic                   negQ, negD;

  div_phase_e  phase;
  logic [31:0] shifted;
  logic [32:0] diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sQ   <= '0;
      qQ   <= '0;
      rQ   <= '0;
      negQ <= 1'b0;
    end else begin
      sQ   <= sD;
      qQ   <= qD;
      rQ   <= rD;
      negQ <= negD;
    end
  end

  // LOAD runs whenever the counter sits at zero, so the dividend is always freshly captured
  // before the first step; counts past DONE simply hold the datapath.
  always_comb begin
    phase   = divPhase(sQ);
    sD      = run ? sQ + 6'd1 : '0;
    qD      = qQ;
    rD      = rQ;
    negD    = negQ;
    shifted = {rQ[30:0], qQ[31]};
    diff    = {1'b0, shifted} - {1'b0, y};

    case (phase)
      PH_LOAD: begin
        negD = u & x[31];
        qD   = (u & x[31]) ? -x : x;
        rD   = '0;
      end
      PH_STEP: begin
        if (!diff[32]) begin
          rD = diff[31:0];
          qD = {qQ[30:0], 1'b1};
        end else begin
          rD = shifted;
          qD = {qQ[30:0], 1'b0};
        end
      end
      default: begin
      end
    endcase
  end

  // Negative dividends were divided as magnitudes; fold the result back to floored form.
  always_comb begin
    stall = run & (sQ != DIV_DONE);
    quot  = qQ;
    rem   = rQ;
    if (negQ) begin
      if (rQ == '0) begin
        quot = -qQ;
        rem  = '0;
      end else begin
        quot = ~qQ;
        rem  = y - rQ;
      end
    end
  end

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider: directed cases, abort/reset scenarios and a
// randomized run compared against an arithmetic floored-division model.
module tb_int_divider;

  logic        clk;
  logic        rst;
  logic        run;
  logic        u;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] quot;
  logic [31:0] rem;

  int testCount;
  int failCount;

  int_divider dut (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .u    (u),
    .x    (x),
    .y    (y),
    .stall(stall),
    .quot (quot),
    .rem  (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Floored division with a non-negative divisor, written directly from the arithmetic
  // definition; divide-by-zero yields the results the algorithm naturally produces.
  function automatic void refDiv(input logic uIn, input logic [31:0] xIn, input logic [31:0] yIn,
                                 output logic [31:0] qOut, output logic [31:0] rOut);
    logic [31:0] mag;
    logic [31:0] q0;
    logic [31:0] r0;
    if (uIn && xIn[31]) begin
      mag = 32'd0 - xIn;
      if (yIn == 32'd0) begin
        qOut = 32'd0;
        rOut = xIn;
      end else begin
        q0 = mag / yIn;
        r0 = mag % yIn;
        if (r0 == 32'd0) begin
          qOut = 32'd0 - q0;
          rOut = 32'd0;
        end else begin
          qOut = 32'd0 - q0 - 32'd1;
          rOut = yIn - r0;
        end
      end
    end else if (yIn == 32'd0) begin
      qOut = 32'hFFFF_FFFF;
      rOut = xIn;
    end else begin
      qOut = xIn / yIn;
      rOut = xIn % yIn;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Waits at negedges while stall is high; returns the number of stalled cycles seen.
  task automatic countStall(output int cycles);
    cycles = 0;
    while (stall === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  // One complete DIV: raise run, scramble x after the load cycle, check latency and result,
  // then drop run for the one mandatory idle cycle.
  task automatic applyStimulus(input string tag, input logic uIn, input logic [31:0] xIn,
                               input logic [31:0] yIn);
    logic [31:0] expQ;
    logic [31:0] expR;
    int          cycles;
    refDiv(uIn, xIn, yIn, expQ, expR);
    @(negedge clk);
    u   = uIn;
    x   = xIn;
    y   = yIn;
    run = 1'b1;
    #1;
    cycles = 1;
    @(negedge clk);
    x = $urandom;
    #1;
    if (stall === 1'b1) begin
      int rest;
      countStall(rest);
      cycles += rest;
    end else begin
      cycles = 1;
    end
    checkOutput({tag, " stallCycles"}, 32'(cycles), 32'd33);
    checkOutput({tag, " quot"}, quot, expQ);
    checkOutput({tag, " rem"}, rem, expR);
    run = 1'b0;
    #1;
    checkOutput({tag, " stallIdle"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [31:0] expQ;
    logic [31:0] expR;
    int          cycles;
    logic [31:0] rx;
    logic [31:0] ry;
    logic        ru;

    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    run = 1'b0;
    u   = 1'b0;
    x   = '0;
    y   = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset quot", quot, 32'd0);
    checkOutput("reset rem", rem, 32'd0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    run = 1'b1;
    #1;
    checkOutput("reset stallEqualsRun", {31'd0, stall}, 32'd1);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("unsigned 100/7", 1'b0, 32'd100, 32'd7);
    applyStimulus("signed -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("signed -8/2", 1'b1, 32'hFFFF_FFF8, 32'd2);
    applyStimulus("signed 7/2", 1'b1, 32'd7, 32'd2);
    applyStimulus("unsigned max/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    applyStimulus("signed minint/1", 1'b1, 32'h8000_0000, 32'd1);
    applyStimulus("unsigned 5/0", 1'b0, 32'd5, 32'd0);
    applyStimulus("signed -9/0", 1'b1, 32'hFFFF_FFF7, 32'd0);
    applyStimulus("unsigned neg-looking/3", 1'b0, 32'hFFFF_FFF9, 32'd3);

    // Reset in the middle of an operation with run still high restarts from scratch.
    @(negedge clk);
    u   = 1'b0;
    x   = 32'd1000;
    y   = 32'd13;
    run = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midReset stall", {31'd0, stall}, 32'd1);
    checkOutput("midReset quot", quot, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    countStall(cycles);
    refDiv(1'b0, 32'd1000, 32'd13, expQ, expR);
    checkOutput("afterReset stallCycles", 32'(cycles), 32'd33);
    checkOutput("afterReset quot", quot, expQ);
    checkOutput("afterReset rem", rem, expR);
    run = 1'b0;

    // Dropping run mid-operation aborts; the next DIV must start at LOAD.
    @(negedge clk);
    u   = 1'b1;
    x   = 32'hFFFF_FC18;
    y   = 32'd3;
    run = 1'b1;
    repeat (20) @(negedge clk);
    run = 1'b0;
    #1;
    checkOutput("abort stall", {31'd0, stall}, 32'd0);
    applyStimulus("afterAbort -1000/7", 1'b1, 32'hFFFF_FC18, 32'd7);

    for (int i = 0; i < 40; i++) begin
      ru = 1'($urandom);
      rx = $urandom;
      if (i % 2 == 0)
        ry = $urandom_range(1, 1000);
      else
        ry = $urandom_range(1, 32'h7FFF_FFFF);
      applyStimulus($sformatf("random%0d", i), ru, rx, ry);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
